// File: rtl/grom_bus_arbiter.sv
// ---------------------------------------------------------------------------
// grom_bus_arbiter
//   Shares the single memory/IO bus between port 0 (CPU bus adapter) and
//   port 1 (DMA/debug loader). Each port uses a req/ack handshake. In IDLE the
//   arbiter picks a winner, latches its request fields onto the bus, holds the
//   bus for one access (one cycle for a write, RD_LAT cycles for a read),
//   then pulses the winner's ack for one cycle in DONE.
//
// Parameters
//   ADDR_W  address width of ports and bus
//   DATA_W  data width of ports and bus
//   RD_LAT  cycles from bus_en rising to valid bus_rdata (legal 1..15)
//   RR      1 = round-robin, 0 = fixed priority (port 0 wins)
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   i_pN_req/addr/we/ioreq/wdata     port N request fields (stable until ack)
//   o_pN_ack                         one-cycle completion pulse to port N
//   o_pN_rdata                       port N read data, held after ack
//   o_bus_en/addr/we/ioreq/wdata     shared bus request side
//   i_bus_rdata                      shared bus read data
//   o_busy                           high whenever the FSM is not IDLE
//   o_gnt                            index of current/last granted port
// ---------------------------------------------------------------------------
module grom_bus_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned RR     = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_p0_req,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic              i_p0_we,
    input  logic              i_p0_ioreq,
    input  logic [DATA_W-1:0] i_p0_wdata,
    output logic              o_p0_ack,
    output logic [DATA_W-1:0] o_p0_rdata,

    input  logic              i_p1_req,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic              i_p1_we,
    input  logic              i_p1_ioreq,
    input  logic [DATA_W-1:0] i_p1_wdata,
    output logic              o_p1_ack,
    output logic [DATA_W-1:0] o_p1_rdata,

    output logic              o_bus_en,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic              o_bus_we,
    output logic              o_bus_ioreq,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic [DATA_W-1:0] i_bus_rdata,

    output logic              o_busy,
    output logic              o_gnt
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_t;

    // Read ACCESS counts down from RD_LAT-1 to 0; the zero cycle is the last.
    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    state_t              r_state,      w_state_nxt;
    logic [3:0]          r_cnt,        w_cnt_nxt;
    logic                r_prio,       w_prio_nxt;   // port favoured on a tie
    logic                r_gnt,        w_gnt_nxt;
    logic                r_bus_en,     w_bus_en_nxt;
    logic [ADDR_W-1:0]   r_bus_addr,   w_bus_addr_nxt;
    logic                r_bus_we,     w_bus_we_nxt;
    logic                r_bus_ioreq,  w_bus_ioreq_nxt;
    logic [DATA_W-1:0]   r_bus_wdata,  w_bus_wdata_nxt;
    logic                r_p0_ack,     w_p0_ack_nxt;
    logic                r_p1_ack,     w_p1_ack_nxt;
    logic [DATA_W-1:0]   r_p0_rdata,   w_p0_rdata_nxt;
    logic [DATA_W-1:0]   r_p1_rdata,   w_p1_rdata_nxt;
    logic                r_busy,       w_busy_nxt;

    logic                w_any_req;
    logic                w_win;

    assign w_any_req = i_p0_req | i_p1_req;

    // A lone requester always wins; a tie goes to the pointer (RR) or port 0.
    always_comb begin
        w_win = 1'b0;
        if (i_p0_req && i_p1_req) begin
            w_win = (RR != 0) ? r_prio : 1'b0;
        end else if (i_p1_req) begin
            w_win = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_prio      <= 1'b0;
            r_gnt       <= 1'b0;
            r_bus_en    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_we    <= 1'b0;
            r_bus_ioreq <= 1'b0;
            r_bus_wdata <= '0;
            r_p0_ack    <= 1'b0;
            r_p1_ack    <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_prio      <= w_prio_nxt;
            r_gnt       <= w_gnt_nxt;
            r_bus_en    <= w_bus_en_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_ioreq <= w_bus_ioreq_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_p0_ack    <= w_p0_ack_nxt;
            r_p1_ack    <= w_p1_ack_nxt;
            r_p0_rdata  <= w_p0_rdata_nxt;
            r_p1_rdata  <= w_p1_rdata_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_prio_nxt      = r_prio;
        w_gnt_nxt       = r_gnt;
        w_bus_en_nxt    = r_bus_en;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_we_nxt    = r_bus_we;
        w_bus_ioreq_nxt = r_bus_ioreq;
        w_bus_wdata_nxt = r_bus_wdata;
        w_p0_ack_nxt    = r_p0_ack;
        w_p1_ack_nxt    = r_p1_ack;
        w_p0_rdata_nxt  = r_p0_rdata;
        w_p1_rdata_nxt  = r_p1_rdata;
        w_busy_nxt      = r_busy;

        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_nxt     = StAccess;
                    w_busy_nxt      = 1'b1;
                    w_bus_en_nxt    = 1'b1;
                    w_gnt_nxt       = w_win;
                    w_prio_nxt      = ~w_win;
                    w_cnt_nxt       = LAT_M1;
                    w_bus_addr_nxt  = w_win ? i_p1_addr  : i_p0_addr;
                    w_bus_we_nxt    = w_win ? i_p1_we    : i_p0_we;
                    w_bus_ioreq_nxt = w_win ? i_p1_ioreq : i_p0_ioreq;
                    w_bus_wdata_nxt = w_win ? i_p1_wdata : i_p0_wdata;
                end
            end

            StAccess: begin
                // Writes take one cycle; reads end when the counter hits zero.
                if (r_bus_we || (r_cnt == 4'd0)) begin
                    w_state_nxt  = StDone;
                    w_bus_en_nxt = 1'b0;
                    w_bus_we_nxt = 1'b0;
                    if (r_gnt) begin
                        w_p1_ack_nxt = 1'b1;
                        if (!r_bus_we) begin
                            w_p1_rdata_nxt = i_bus_rdata;
                        end
                    end else begin
                        w_p0_ack_nxt = 1'b1;
                        if (!r_bus_we) begin
                            w_p0_rdata_nxt = i_bus_rdata;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            StDone: begin
                w_state_nxt  = StIdle;
                w_busy_nxt   = 1'b0;
                w_p0_ack_nxt = 1'b0;
                w_p1_ack_nxt = 1'b0;
            end

            default: begin
                w_state_nxt  = StIdle;
                w_busy_nxt   = 1'b0;
                w_bus_en_nxt = 1'b0;
                w_bus_we_nxt = 1'b0;
                w_p0_ack_nxt = 1'b0;
                w_p1_ack_nxt = 1'b0;
            end
        endcase
    end

    assign o_p0_ack    = r_p0_ack;
    assign o_p0_rdata  = r_p0_rdata;
    assign o_p1_ack    = r_p1_ack;
    assign o_p1_rdata  = r_p1_rdata;
    assign o_bus_en    = r_bus_en;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_we    = r_bus_we;
    assign o_bus_ioreq = r_bus_ioreq;
    assign o_bus_wdata = r_bus_wdata;
    assign o_busy      = r_busy;
    assign o_gnt       = r_gnt;

endmodule

// File: tb/tb_grom_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_grom_bus_arbiter
//   Directed bench for grom_bus_arbiter. Two instances share all inputs:
//   u_rr (RR=1, RD_LAT=2) and u_fp (RR=0, RD_LAT=1, the single-cycle read
//   boundary). Inputs change and outputs are sampled 1 ns after each rising
//   edge; "after edge N+k" below means the cycle following that edge.
// ---------------------------------------------------------------------------
module tb_grom_bus_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;

    logic              p0_req, p0_we, p0_ioreq;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p1_req, p1_we, p1_ioreq;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [DATA_W-1:0] bus_rdata;

    logic              rr_p0_ack, rr_p1_ack, rr_bus_en, rr_bus_we, rr_bus_ioreq;
    logic              rr_busy, rr_gnt;
    logic [DATA_W-1:0] rr_p0_rdata, rr_p1_rdata, rr_bus_wdata;
    logic [ADDR_W-1:0] rr_bus_addr;

    logic              fp_p0_ack, fp_p1_ack, fp_bus_en, fp_bus_we, fp_bus_ioreq;
    logic              fp_busy, fp_gnt;
    logic [DATA_W-1:0] fp_p0_rdata, fp_p1_rdata, fp_bus_wdata;
    logic [ADDR_W-1:0] fp_bus_addr;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    grom_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .RR(1)) u_rr (
        .clk(clk), .reset(reset),
        .i_p0_req(p0_req), .i_p0_addr(p0_addr), .i_p0_we(p0_we),
        .i_p0_ioreq(p0_ioreq), .i_p0_wdata(p0_wdata),
        .o_p0_ack(rr_p0_ack), .o_p0_rdata(rr_p0_rdata),
        .i_p1_req(p1_req), .i_p1_addr(p1_addr), .i_p1_we(p1_we),
        .i_p1_ioreq(p1_ioreq), .i_p1_wdata(p1_wdata),
        .o_p1_ack(rr_p1_ack), .o_p1_rdata(rr_p1_rdata),
        .o_bus_en(rr_bus_en), .o_bus_addr(rr_bus_addr), .o_bus_we(rr_bus_we),
        .o_bus_ioreq(rr_bus_ioreq), .o_bus_wdata(rr_bus_wdata),
        .i_bus_rdata(bus_rdata), .o_busy(rr_busy), .o_gnt(rr_gnt)
    );

    grom_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .RR(0)) u_fp (
        .clk(clk), .reset(reset),
        .i_p0_req(p0_req), .i_p0_addr(p0_addr), .i_p0_we(p0_we),
        .i_p0_ioreq(p0_ioreq), .i_p0_wdata(p0_wdata),
        .o_p0_ack(fp_p0_ack), .o_p0_rdata(fp_p0_rdata),
        .i_p1_req(p1_req), .i_p1_addr(p1_addr), .i_p1_we(p1_we),
        .i_p1_ioreq(p1_ioreq), .i_p1_wdata(p1_wdata),
        .o_p1_ack(fp_p1_ack), .o_p1_rdata(fp_p1_rdata),
        .o_bus_en(fp_bus_en), .o_bus_addr(fp_bus_addr), .o_bus_we(fp_bus_we),
        .o_bus_ioreq(fp_bus_ioreq), .o_bus_wdata(fp_bus_wdata),
        .i_bus_rdata(bus_rdata), .o_busy(fp_busy), .o_gnt(fp_gnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_acks;
    int fp_acks;

    initial begin
        reset    = 1'b1;
        p0_req   = 1'b0; p0_we = 1'b0; p0_ioreq = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req   = 1'b0; p1_we = 1'b0; p1_ioreq = 1'b0; p1_addr = '0; p1_wdata = '0;
        bus_rdata = '0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_bus_en",   32'(rr_bus_en),   32'd0);
        check_eq("rst_bus_we",   32'(rr_bus_we),   32'd0);
        check_eq("rst_bus_addr", 32'(rr_bus_addr), 32'd0);
        check_eq("rst_busy",     32'(rr_busy),     32'd0);
        check_eq("rst_gnt",      32'(rr_gnt),      32'd0);
        check_eq("rst_p0_ack",   32'(rr_p0_ack),   32'd0);
        check_eq("rst_p1_ack",   32'(rr_p1_ack),   32'd0);
        check_eq("rst_fp_busy",  32'(fp_busy),     32'd0);

        reset = 1'b0;
        tick();

        // 1: p0 read 0x123, bus returns 0xA5
        p0_req = 1'b1; p0_addr = 12'h123; p0_we = 1'b0; bus_rdata = 8'hA5;
        tick();  // edge N
        check_eq("t1_bus_en_n1", 32'(rr_bus_en),   32'd1);
        check_eq("t1_addr",      32'(rr_bus_addr), 32'h123);
        check_eq("t1_we",        32'(rr_bus_we),   32'd0);
        check_eq("t1_busy",      32'(rr_busy),     32'd1);
        check_eq("t1_gnt",       32'(rr_gnt),      32'd0);
        check_eq("t1_ack_n1",    32'(rr_p0_ack),   32'd0);
        check_eq("t1_fp_en",     32'(fp_bus_en),   32'd1);
        tick();  // N+1
        check_eq("t1_bus_en_n2", 32'(rr_bus_en),   32'd1);
        check_eq("t1_ack_n2",    32'(rr_p0_ack),   32'd0);
        check_eq("t1_fp_ack",    32'(fp_p0_ack),   32'd1);
        check_eq("t1_fp_rdata",  32'(fp_p0_rdata), 32'hA5);
        check_eq("t1_fp_en_off", 32'(fp_bus_en),   32'd0);
        tick();  // N+2
        check_eq("t1_bus_en_off", 32'(rr_bus_en),   32'd0);
        check_eq("t1_ack_n3",     32'(rr_p0_ack),   32'd1);
        check_eq("t1_rdata",      32'(rr_p0_rdata), 32'hA5);
        check_eq("t1_busy_done",  32'(rr_busy),     32'd1);
        check_eq("t1_fp_ack_off", 32'(fp_p0_ack),   32'd0);
        p0_req = 1'b0; bus_rdata = 8'h5A;
        tick();  // N+3
        check_eq("t1_ack_off",   32'(rr_p0_ack),   32'd0);
        check_eq("t1_busy_idle", 32'(rr_busy),     32'd0);
        check_eq("t1_rdata_hold", 32'(rr_p0_rdata), 32'hA5);

        // 2: p1 IO write 0x0FF <- 0x3C
        p1_req = 1'b1; p1_addr = 12'h0FF; p1_we = 1'b1; p1_ioreq = 1'b1; p1_wdata = 8'h3C;
        tick();  // edge N
        check_eq("t2_bus_en",  32'(rr_bus_en),    32'd1);
        check_eq("t2_we",      32'(rr_bus_we),    32'd1);
        check_eq("t2_ioreq",   32'(rr_bus_ioreq), 32'd1);
        check_eq("t2_addr",    32'(rr_bus_addr),  32'h0FF);
        check_eq("t2_wdata",   32'(rr_bus_wdata), 32'h3C);
        check_eq("t2_gnt",     32'(rr_gnt),       32'd1);
        check_eq("t2_fp_gnt",  32'(fp_gnt),       32'd1);
        tick();  // N+1
        check_eq("t2_p1_ack",  32'(rr_p1_ack),    32'd1);
        check_eq("t2_p0_ack",  32'(rr_p0_ack),    32'd0);
        check_eq("t2_we_off",  32'(rr_bus_we),    32'd0);
        check_eq("t2_en_off",  32'(rr_bus_en),    32'd0);
        check_eq("t2_fp_ack",  32'(fp_p1_ack),    32'd1);
        p1_req = 1'b0; p1_we = 1'b0; p1_ioreq = 1'b0;
        tick();
        check_eq("t2_ack_off",     32'(rr_p1_ack),   32'd0);
        check_eq("t2_loser_rdata", 32'(rr_p0_rdata), 32'hA5);
        check_eq("t2_p1_rdata",    32'(rr_p1_rdata), 32'h00);

        // 3/4: both ports read continuously
        p0_addr = 12'h010; p0_we = 1'b0;
        p1_addr = 12'h020; p1_we = 1'b0;
        bus_rdata = 8'h77;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();  // after edge N+k
            check_eq($sformatf("t3_rr_p0_ack_%0d", k), 32'(rr_p0_ack),
                     32'((k == 2) || (k == 10)));
            check_eq($sformatf("t3_rr_p1_ack_%0d", k), 32'(rr_p1_ack),
                     32'((k == 6) || (k == 14)));
            check_eq($sformatf("t3_rr_gnt_%0d", k), 32'(rr_gnt), 32'((k / 4) % 2));
            check_eq($sformatf("t4_fp_p0_ack_%0d", k), 32'(fp_p0_ack),
                     32'((k % 3) == 1));
            check_eq($sformatf("t4_fp_p1_ack_%0d", k), 32'(fp_p1_ack), 32'd0);
            check_eq($sformatf("t4_fp_gnt_%0d", k), 32'(fp_gnt), 32'd0);
            if (k == 4) check_eq("t3_addr_p1", 32'(rr_bus_addr), 32'h020);
            if (k == 8) check_eq("t3_addr_p0", 32'(rr_bus_addr), 32'h010);
            if (k == 6) check_eq("t3_p1_rdata", 32'(rr_p1_rdata), 32'h77);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (3) tick();

        // 5: reset during a p0 read ACCESS
        p0_req = 1'b1; p0_addr = 12'h200; bus_rdata = 8'hC3;
        tick();  // edge N
        check_eq("t5_bus_en", 32'(rr_bus_en), 32'd1);
        p0_req = 1'b0; reset = 1'b1;
        tick();
        check_eq("t5_en_abort",   32'(rr_bus_en),   32'd0);
        check_eq("t5_busy_abort", 32'(rr_busy),     32'd0);
        check_eq("t5_ack_abort",  32'(rr_p0_ack),   32'd0);
        check_eq("t5_rdata_rst",  32'(rr_p0_rdata), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("t5_no_ack_%0d", k), 32'(rr_p0_ack), 32'd0);
        end
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 12'h345; p1_wdata = 8'h11;
        tick();
        check_eq("t5_p1_gnt",  32'(rr_gnt),      32'd1);
        check_eq("t5_p1_en",   32'(rr_bus_en),   32'd1);
        check_eq("t5_p1_addr", 32'(rr_bus_addr), 32'h345);
        p1_req = 1'b0;
        tick();
        check_eq("t5_p1_ack",  32'(rr_p1_ack),   32'd1);
        p1_we = 1'b0;
        repeat (2) tick();

        // 6: p0 drops req one cycle after grant
        p0_req = 1'b1; p0_addr = 12'h0AB; p0_we = 1'b0; bus_rdata = 8'h99;
        rr_acks = 0; fp_acks = 0;
        tick();  // edge N
        check_eq("t6_bus_en", 32'(rr_bus_en), 32'd1);
        p0_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (rr_p0_ack) rr_acks++;
            if (fp_p0_ack) fp_acks++;
            if (k == 2) check_eq("t6_ack_n3", 32'(rr_p0_ack), 32'd1);
        end
        check_eq("t6_rr_ack_cnt", 32'(rr_acks),     32'd1);
        check_eq("t6_fp_ack_cnt", 32'(fp_acks),     32'd1);
        check_eq("t6_en_idle",    32'(rr_bus_en),   32'd0);
        check_eq("t6_busy_idle",  32'(rr_busy),     32'd0);
        check_eq("t6_rdata",      32'(rr_p0_rdata), 32'h99);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
